// File: rtl/mux_8x1.sv
// mux_8x1: 8:1 bitwise selector with combinational out and registered out_q; ports clk, rst, in0..in7, sel, out, out_q
module mux_8x1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q
);
  logic [WIDTH-1:0] l1_0, l1_1, l1_2, l1_3, l2_0, l2_1, l3;
  always_comb begin
    l1_0 = sel[0] ? in1 : in0;
    l1_1 = sel[0] ? in3 : in2;
    l1_2 = sel[0] ? in5 : in4;
    l1_3 = sel[0] ? in7 : in6;
    l2_0 = sel[1] ? l1_1 : l1_0;
    l2_1 = sel[1] ? l1_3 : l1_2;
    l3   = sel[2] ? l2_1 : l2_0;
    out  = $isunknown(sel) ? '0 : l3;
  end
  always_ff @(posedge clk) out_q <= rst ? '0 : out;
endmodule

// File: tb/tb_mux_8x1.sv
// tb_mux_8x1: directed checks of mux_8x1 at WIDTH 1 and 7
module tb_mux_8x1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] sel = 3'd0;
  logic [0:0] a [8];
  logic [6:0] b [8];
  logic [0:0] o1, q1;
  logic [6:0] o7, q7;
  int n = 0;
  int errs = 0;
  logic [0:0] e1 [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [0:0] e2 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [6:0] rows [8] = '{7'b0000100, 7'b1110000, 7'b1110111, 7'b0000111,
                           7'b0000111, 7'b1000000, 7'b0111000, 7'b1000000};
  always #5 clk = ~clk;
  mux_8x1 #(.WIDTH(1)) u1 (
    .in0(a[0]), .in1(a[1]), .in2(a[2]), .in3(a[3]),
    .in4(a[4]), .in5(a[5]), .in6(a[6]), .in7(a[7]),
    .sel(sel), .out(o1), .clk(clk), .rst(rst), .out_q(q1)
  );
  mux_8x1 #(.WIDTH(7)) u7 (
    .in0(b[0]), .in1(b[1]), .in2(b[2]), .in3(b[3]),
    .in4(b[4]), .in5(b[5]), .in6(b[6]), .in7(b[7]),
    .sel(sel), .out(o7), .clk(clk), .rst(rst), .out_q(q7)
  );
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      a[i] = e1[i];
      b[i] = 7'd0;
    end
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1 chk($sformatf("sweep0_sel%0d", s), 7'(o1), 7'(e1[s]));
      #9;
    end
    for (int i = 0; i < 8; i++) a[i] = e2[i];
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1 chk($sformatf("sweep6_sel%0d", s), 7'(o1), 7'(e2[s]));
      #9;
    end
    sel = 3'd3;
    #1 chk("in3_lo", 7'(o1), 7'd0);
    a[3] = 1'b1;
    #1 chk("in3_hi", 7'(o1), 7'd1);
    a[3] = 1'b0;
    #1 chk("in3_lo2", 7'(o1), 7'd0);
    for (int i = 0; i < 8; i++) if (i != 3) a[i] = ~e2[i];
    #1 chk("others_ignored", 7'(o1), 7'd0);
    for (int i = 0; i < 8; i++) a[i] = e2[i];
    for (int i = 0; i < 8; i++) b[i] = rows[i];
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1 chk($sformatf("row_sel%0d", s), o7, rows[s]);
      #9;
    end
    rst = 1'b1;
    edge_wait();
    edge_wait();
    chk("rst_q1", 7'(q1), 7'd0);
    chk("rst_q7", q7, 7'd0);
    sel = 3'd2;
    rst = 1'b0;
    edge_wait();
    chk("first_q1", 7'(q1), 7'd1);
    chk("first_q7", q7, 7'b1110111);
    sel = 3'd6;
    #1 chk("sel6_out", 7'(o1), 7'd0);
    chk("sel6_q_hold", 7'(q1), 7'd1);
    edge_wait();
    chk("sel6_q", 7'(q1), 7'd0);
    chk("sel6_q7", q7, 7'b0111000);
    sel = 3'd2;
    edge_wait();
    chk("q_back1", 7'(q1), 7'd1);
    rst = 1'b1;
    edge_wait();
    chk("mid_rst_q", 7'(q1), 7'd0);
    chk("mid_rst_out", 7'(o1), 7'd1);
    chk("mid_rst_q7", q7, 7'd0);
    rst = 1'b0;
    edge_wait();
    chk("after_rst_q", 7'(q1), 7'd1);
    a[4] = 1'b0;
    a[6] = 1'b0;
    b[4] = 7'd0;
    b[6] = 7'd0;
    sel = 3'b1x0;
    #1 chk("selx_out1", 7'(o1), 7'd0);
    chk("selx_out7", o7, 7'd0);
    edge_wait();
    chk("selx_q1", 7'(q1), 7'd0);
    chk("selx_q7", q7, 7'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule

// File: doc/mux_8x1.md
# mux_8x1

Eight-input, one-output selector with a 3-bit select, used bit-sliced by the map selector to pick one of eight stored map rows per display bit. It provides the selected value combinationally for direct use and as a registered copy for clocked consumers. The data width is parameterised; existing map-selector instances use width 1.

## Interface

**Parameters**
- `WIDTH`, default 1: width of each data input and of both outputs.

**Ports** (name, direction, width, meaning)
- `clk`, input, 1: system clock; all state updates on its rising edge. One clock; reset is synchronous and active-high.
- `rst`, input, 1: synchronous, active-high reset.
- `in0`…`in7`, input, WIDTH each: data candidates 0 through 7.
- `sel`, input, 3: select code; `sel[2]` is the MSB.
- `out`, output, WIDTH: combinational selected value.
- `out_q`, output, WIDTH: registered copy of `out`.

**Port order** for positional instantiation: `in0`…`in7`, `sel`, `out`, `clk`, `rst`, `out_q`.
- Existing map-selector instances bind the first ten ports positionally.
- Those instances must leave `clk`/`rst` tied to 0 and `out_q` open, or be updated to connect them.

## Operation

**Selection**
- `out` equals `in[sel]`: `sel`=3'b000 selects `in0`, 3'b001 selects `in1`, … 3'b111 selects `in7`.

**Structure:** a three-level tree of 2:1 selectors.
- Level 1: `sel[0]` chooses between pairs (in0/in1, in2/in3, in4/in5, in6/in7).
- Level 2: `sel[1]` chooses between the level-1 results.
- Level 3: `sel[2]` chooses the final value.
- Each 2:1 stage is bitwise across WIDTH. No bit of a word mixes with another bit.

**Registered output (`out_q`)**
- On each rising `clk`: if `rst`=1, `out_q` ← 0. Otherwise `out_q` ← `out`.

**Non-binary select**
- If `sel` holds any X/Z bit in simulation, `out` is all zeros.
- `out_q` then loads zeros on the next non-reset edge.
- Synthesis is free to treat this case as don't-care.

**Other rules**
- No other state. No enable and no handshake; `out_q` samples every cycle.

## Timing

- `out`: purely combinational from `in0`…`in7` and `sel`, with zero-cycle latency. It is not affected by `clk` or `rst`.
- `out_q`: one-cycle latency. It reflects the `sel`/`in*` values present at the preceding rising edge.
- **Reset value:** `out_q` = 0 from the first rising edge with `rst`=1, held while `rst` stays 1.
- **First data after reset:** on the first edge with `rst`=0, `out_q` loads the current `out`.
- **Reset mid-operation:** `out_q` is cleared on the next edge regardless of `sel`. `out` continues to track its inputs throughout.
- **Simultaneous `sel` and data changes:** `out` settles to the new `in[new sel]` with no memory of the old select. `out_q` captures whatever has settled at the edge.
- **Before the first reset:** `out_q` is undefined (X in simulation); `out` is valid immediately.

## Test plan

1. **Bit-0 sweep, WIDTH=1.** Set in0..in7 = 0,0,1,1,1,0,0,0. Sweep `sel` 0→7, 10 time units per step. Expect `out` = 0,0,1,1,1,0,0,0 in the same step.
2. **Bit-6 sweep, WIDTH=1.** Set in0..in7 = 1,1,1,0,1,1,0,1 and sweep `sel` 0→7. Expect `out` = 1,1,1,0,1,1,0,1. Then set `sel`=3'b011 and toggle `in3` 0→1→0; expect `out` to follow, and no other input change to affect it.
3. **Registered path.** Hold `rst`=1 for 2 cycles: `out_q`=0. Release reset with `sel`=2 and in2=1: `out_q`=1 after one edge. Change `sel` to 6 (in6=0): `out`=0 immediately, `out_q`=0 after the next edge.
4. **Reset mid-operation.** With `out_q`=1, assert `rst` for one cycle. Expect `out_q`=0 on that edge, `out` unchanged. After deassertion, `out_q` returns to 1 on the next edge.
5. **WIDTH=7 map rows.** Set in0..in7 = 7'b0000100, 7'b1110000, 7'b1110111, 7'b0000111, 7'b0000111, 7'b1000000, 7'b0111000, 7'b1000000. Sweep `sel` 0→7. Expect `out` to equal each row in order, with each bit selected independently.
6. **Unknown select.** Drive `sel`=3'b1x0. Expect `out`=0. After one clock with `rst`=0, expect `out_q`=0.
